// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with runtime seed load, advance counter
// and period-wrap pulse.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN. When it is defined, advancing
// out of the all-zero state restores SEED and pulses lockup_o. Otherwise
// lockup_o is tied low and the zero state is sticky.
module lfsr_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 'hB8,
    parameter logic [WIDTH-1:0] SEED  = 'h1,
    parameter int unsigned      STEP  = 1,
    parameter int unsigned      OUT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             next_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [OUT_W-1:0] rand_o,
    output logic [WIDTH-1:0] state_o,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o,
    output logic             lockup_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    // State after STEP shifts; compared against seed_q for wrap detection.
    logic [WIDTH-1:0] adv_state;
`ifdef LFSR_LOCKUP_RECOVER_EN
    logic             lockup_q, lockup_d;
`endif

    // One Fibonacci shift: feedback is the XOR of the tapped bits, shifted in at bit 0.
    function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] s);
        logic fb;
        fb = ^(s & TAPS);
        return {s[WIDTH-2:0], fb};
    endfunction

    // Unrolled STEP-fold shift of the current state.
    always_comb begin
        adv_state = state_q;
        for (int unsigned i = 0; i < STEP; i++) begin
            adv_state = shl(adv_state);
        end
    end

    // Next-state selection: load beats advance; idle holds state and clears pulses.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        count_d = count_q;
        wrap_d  = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        lockup_d = 1'b0;
`endif
        if (load_i) begin
            state_d = seed_i;
            seed_d  = seed_i;
            count_d = '0;
        end
`ifdef LFSR_LOCKUP_RECOVER_EN
        else if (next_i && (state_q == '0)) begin
            state_d  = SEED;
            seed_d   = SEED;
            count_d  = '0;
            lockup_d = 1'b1;
        end
`endif
        else if (next_i) begin
            state_d = adv_state;
            if (adv_state == seed_q) begin
                wrap_d  = 1'b1;
                count_d = '0;
            end else if (count_q != '1) begin
                // Saturate rather than roll over so a stuck count stays visible.
                count_d = count_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED;
            seed_q  <= SEED;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef LFSR_LOCKUP_RECOVER_EN
    // Lockup pulse register, present only with zero-state recovery.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= lockup_d;
        end
    end

    assign lockup_o = lockup_q;
`else
    assign lockup_o = 1'b0;
`endif

    assign rand_o  = state_q[OUT_W-1:0];
    assign state_o = state_q;
    assign count_o = count_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: a scoreboard model of the default build plus
// directed constant checks, and a STEP=2 instance for the multi-shift case.
module tb_lfsr_gen;

    logic       clk;
    logic       rst_n;
    logic       next;
    logic       load;
    logic [7:0] seed;

    logic [4:0] rand_a;
    logic [7:0] state_a, count_a;
    logic       wrap_a, lockup_a;

    logic [4:0] rand_b;
    logic [7:0] state_b, count_b;
    logic       wrap_b, lockup_b;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] st;
        logic [7:0] cnt;
        logic       wr;
        logic       lk;
    } exp_t;

    exp_t sb[$];

    // Reference model state for the default instance.
    logic [7:0] m_state, m_seed, m_count;
    logic       m_wrap, m_lock;

    lfsr_gen u_dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .next_i   (next),
        .load_i   (load),
        .seed_i   (seed),
        .rand_o   (rand_a),
        .state_o  (state_a),
        .count_o  (count_a),
        .wrap_o   (wrap_a),
        .lockup_o (lockup_a)
    );

    lfsr_gen #(.STEP(2)) u_dut2 (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .next_i   (next),
        .load_i   (load),
        .seed_i   (seed),
        .rand_o   (rand_b),
        .state_o  (state_b),
        .count_o  (count_b),
        .wrap_o   (wrap_b),
        .lockup_o (lockup_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // x^8 + x^6 + x^5 + x^4 + 1 written out bit by bit.
    function automatic logic [7:0] ref_next(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        m_state = 8'h01;
        m_seed  = 8'h01;
        m_count = 8'h00;
        m_wrap  = 1'b0;
        m_lock  = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle of stimulus, push the model's expectation, then compare after the edge.
    task automatic drive(input logic nx, input logic ld, input logic [7:0] sd);
        exp_t       e;
        logic [7:0] nxt;
        @(negedge clk);
        next = nx;
        load = ld;
        seed = sd;
        m_wrap = 1'b0;
        m_lock = 1'b0;
        if (ld) begin
            m_state = sd;
            m_seed  = sd;
            m_count = 8'h00;
        end else if (nx) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (m_state == 8'h00) begin
                m_state = 8'h01;
                m_seed  = 8'h01;
                m_count = 8'h00;
                m_lock  = 1'b1;
            end else begin
`else
            begin
`endif
                nxt    = ref_next(m_state);
                m_wrap = (nxt == m_seed);
                if (m_wrap) m_count = 8'h00;
                else if (m_count != 8'hFF) m_count = m_count + 8'h01;
                m_state = nxt;
            end
        end
        e.st  = m_state;
        e.cnt = m_count;
        e.wr  = m_wrap;
        e.lk  = m_lock;
        sb.push_back(e);
        @(posedge clk);
        #1;
        next = 1'b0;
        load = 1'b0;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("sb_state", 32'(state_a), 32'(e.st));
            chk("sb_rand", 32'(rand_a), 32'(e.st[4:0]));
            chk("sb_count", 32'(count_a), 32'(e.cnt));
            chk("sb_wrap", 32'(wrap_a), 32'(e.wr));
            chk("sb_lockup", 32'(lockup_a), 32'(e.lk));
        end
    endtask

    initial begin
        logic [7:0] exp_st[7];
        logic [4:0] exp_rd[7];
        logic [7:0] exp_b[3];
        exp_st = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        exp_rd = '{5'h02, 5'h04, 5'h08, 5'h11, 5'h03, 5'h07, 5'h0E};
        exp_b  = '{8'h04, 8'h11, 8'h47};

        rst_n = 1'b0;
        next  = 1'b0;
        load  = 1'b0;
        seed  = 8'h00;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state_a), 32'h01);
        chk("rst_rand", 32'(rand_a), 32'h01);
        chk("rst_count", 32'(count_a), 32'h00);
        chk("rst_wrap", 32'(wrap_a), 32'h0);
        chk("rst_lockup", 32'(lockup_a), 32'h0);
        chk("rst_state2", 32'(state_b), 32'h01);
        rst_n = 1'b1;

        // Seven single advances, and the STEP=2 instance alongside.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 8'h00);
            chk("t1_state", 32'(state_a), 32'(exp_st[i]));
            chk("t1_rand", 32'(rand_a), 32'(exp_rd[i]));
            chk("t1_count", 32'(count_a), i + 1);
            if (i < 3) begin
                chk("t3_state2", 32'(state_b), 32'(exp_b[i]));
                chk("t3_count2", 32'(count_b), i + 1);
                chk("t3_wrap2", 32'(wrap_b), 32'h0);
                chk("t3_lockup2", 32'(lockup_b), 32'h0);
            end
        end

        // Full period: the 255th advance returns to the seed.
        do_reset();
        for (int i = 0; i < 255; i++) drive(1'b1, 1'b0, 8'h00);
        chk("t2_wrap_state", 32'(state_a), 32'h01);
        chk("t2_wrap_pulse", 32'(wrap_a), 32'h1);
        chk("t2_wrap_count", 32'(count_a), 32'h00);
        drive(1'b1, 1'b0, 8'h00);
        chk("t2_after_state", 32'(state_a), 32'h02);
        chk("t2_after_count", 32'(count_a), 32'h01);
        chk("t2_after_wrap", 32'(wrap_a), 32'h0);

        // Load beats next in the same cycle.
        drive(1'b1, 1'b1, 8'h47);
        chk("t4_load_state", 32'(state_a), 32'h47);
        chk("t4_load_count", 32'(count_a), 32'h00);
        drive(1'b1, 1'b0, 8'h00);
        chk("t4_adv_state", 32'(state_a), 32'h8E);
        drive(1'b0, 1'b0, 8'h00);
        chk("t4_idle_state", 32'(state_a), 32'h8E);

        // Asynchronous reset between clock edges.
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_async_state", 32'(state_a), 32'h01);
        chk("t5_async_count", 32'(count_a), 32'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_hold_state", 32'(state_a), 32'h01);
        chk("t5_hold_count", 32'(count_a), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero load followed by advances.
        drive(1'b0, 1'b1, 8'h00);
        chk("t6_load_zero", 32'(state_a), 32'h00);
        drive(1'b1, 1'b0, 8'h00);
`ifdef LFSR_LOCKUP_RECOVER_EN
        chk("t6_rec_state", 32'(state_a), 32'h01);
        chk("t6_rec_lockup", 32'(lockup_a), 32'h1);
        chk("t6_rec_wrap", 32'(wrap_a), 32'h0);
        drive(1'b0, 1'b0, 8'h00);
        chk("t6_rec_lockup_end", 32'(lockup_a), 32'h0);
        drive(1'b1, 1'b0, 8'h00);
        chk("t6_rec_next", 32'(state_a), 32'h02);
`else
        chk("t6_stuck_state", 32'(state_a), 32'h00);
        chk("t6_stuck_wrap", 32'(wrap_a), 32'h1);
        chk("t6_stuck_lockup", 32'(lockup_a), 32'h0);
        drive(1'b0, 1'b0, 8'h00);
        chk("t6_stuck_wrap_end", 32'(wrap_a), 32'h0);
        drive(1'b1, 1'b0, 8'h00);
        chk("t6_stuck_again", 32'(state_a), 32'h00);
        chk("t6_stuck_wrap2", 32'(wrap_a), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
